ram_port_master: RTL and testbench



---
 rtl/mem_pkg.sv | 16 +
 rtl/sync_small_fifo.sv | 59 +++++
 rtl/ram_port_master.sv | 118 +++++++++++
 tb/tb_ram_port_master.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared response type and helpers for the RAM port initiator and its response buffer.
package mem_pkg;

  localparam int MAX_NUM_WE = 64;

  // Response word at the default 32-bit width; wider instances declare their own.
  typedef struct packed {
    logic        write;
    logic [31:0] rdata;
  } mem_rsp_t;

  function automatic logic is_write(input logic [MAX_NUM_WE-1:0] we);
    return |we;
  endfunction

endpackage

// File: rtl/sync_small_fifo.sv
// Small register-based FIFO with a combinational head, used as the response buffer.
module sync_small_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));

  assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_o));
  assert property (@(posedge clk) disable iff (!rst_n) !(pop_i && empty_o));

endmodule

// File: rtl/ram_port_master.sv
// Drives one RAM port from a valid/ready request stream and returns the fixed-latency
// read data as a valid/ready response stream, buffering it under backpressure.
module ram_port_master
  import mem_pkg::*;
#(
  parameter int DATA_DEPTH       = 256,
  parameter int DATA_WIDTH       = 32,
  parameter int BYTE_WRITE_WIDTH = 32,
  parameter int RSP_DEPTH        = 2,
  localparam int ADDR_WIDTH = $clog2(DATA_DEPTH),
  localparam int NUM_WE     = DATA_WIDTH / BYTE_WRITE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [NUM_WE-1:0]     req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_write_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  ram_en_o,
  output logic [NUM_WE-1:0]     ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic                  write;
    logic [DATA_WIDTH-1:0] rdata;
  } rsp_t;

  logic             fire;
  logic             inflight_q, inflight_d;
  logic             is_write_q, is_write_d;
  rsp_t             beat_rsp, fifo_head, rsp_out;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0] cnt;

  assign fire        = req_valid_i && req_ready_o;
  assign ram_en_o    = fire;
  assign ram_we_o    = fire ? req_we_i : '0;
  assign ram_addr_o  = req_addr_i;
  assign ram_wdata_o = req_wdata_i;

  always_comb begin
    inflight_d = fire;
    is_write_d = fire ? is_write(MAX_NUM_WE'(req_we_i)) : is_write_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      is_write_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      is_write_q <= is_write_d;
    end
  end

  // The cycle after a fire carries the RAM read data: the return beat.
  always_comb begin
    beat_rsp.write = is_write_q;
    beat_rsp.rdata = is_write_q ? '0 : ram_rdata_i;
  end

  // Bypass only when nothing is buffered, so responses never overtake each other.
  always_comb begin
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_out     = fifo_head;
    if (inflight_q && fifo_empty) begin
      rsp_valid_o = 1'b1;
      rsp_out     = beat_rsp;
      fifo_push   = !rsp_ready_i;
    end else if (inflight_q) begin
      rsp_valid_o = 1'b1;
      fifo_push   = 1'b1;
      fifo_pop    = rsp_ready_i;
    end else begin
      rsp_valid_o = !fifo_empty;
      fifo_pop    = !fifo_empty && rsp_ready_i;
    end
  end

  assign rsp_write_o = rsp_out.write;
  assign rsp_rdata_o = rsp_out.rdata;

  // Credit: every accepted request is guaranteed a buffer slot for its return beat.
  assign req_ready_o = rst_n &&
                       (((int'(cnt) + int'(inflight_q)) < RSP_DEPTH) ||
                        (rsp_valid_o && rsp_ready_i));

  sync_small_fifo #(
    .DEPTH(RSP_DEPTH),
    .WIDTH($bits(rsp_t))
  ) u_rsp_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (fifo_push),
    .pop_i  (fifo_pop),
    .din_i  (beat_rsp),
    .dout_o (fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(cnt)
  );

  assert property (@(posedge clk) (DATA_WIDTH % BYTE_WRITE_WIDTH) == 0);
  assert property (@(posedge clk) disable iff (!rst_n) !(inflight_q && fifo_full));

endmodule

// File: tb/tb_ram_port_master.sv
// Randomized self-checking bench: a byte-lane RAM model as environment and an
// acceptance-order scoreboard with a golden memory as the reference.
module tb_ram_port_master;

  localparam int DEPTH = 256;
  localparam int DW    = 32;
  localparam int BW    = 8;
  localparam int NWE   = DW / BW;
  localparam int AW    = 8;
  localparam int RD    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [NWE-1:0] req_we_i = '0;
  logic [AW-1:0] req_addr_i = '0;
  logic [DW-1:0] req_wdata_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic          rsp_write_o;
  logic [DW-1:0] rsp_rdata_o;
  logic          ram_en_o;
  logic [NWE-1:0] ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_wdata_o;
  logic [DW-1:0] ram_rdata_i = '0;

  ram_port_master #(
    .DATA_DEPTH(DEPTH), .DATA_WIDTH(DW), .BYTE_WRITE_WIDTH(BW), .RSP_DEPTH(RD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_write_o(rsp_write_o),
    .rsp_rdata_o(rsp_rdata_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  always #5 clk = ~clk;

  // Environment RAM: one-cycle registered read, per-lane writes.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (ram_en_o) begin
      ram_rdata_i <= ram[ram_addr_o];
      for (int l = 0; l < NWE; l++)
        if (ram_we_o[l]) ram[ram_addr_o][l*BW +: BW] <= ram_wdata_o[l*BW +: BW];
    end
  end

  // Reference: golden memory updated at acceptance, responses expected in acceptance order.
  typedef struct {
    logic          w;
    logic [DW-1:0] d;
    int            c;
  } exp_t;
  logic [DW-1:0] gold [DEPTH];
  exp_t          q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic          acc, got, rdy_seen, en_seen, obs_w, have_exp, exp_w;
  logic [NWE-1:0] we_seen, we_drv;
  logic [DW-1:0] obs_d, exp_d;
  int            exp_lat;

  task automatic cycle();
    exp_t e;
    @(negedge clk);
    rdy_seen = req_ready_o;
    acc      = req_valid_i && req_ready_o;
    got      = rsp_valid_o && rsp_ready_i;
    en_seen  = ram_en_o;
    we_seen  = ram_we_o;
    we_drv   = req_we_i;
    obs_w    = rsp_write_o;
    obs_d    = rsp_rdata_o;
    have_exp = 1'b0;
    if (got && q.size() > 0) begin
      e        = q.pop_front();
      have_exp = 1'b1;
      exp_w    = e.w;
      exp_d    = e.d;
      exp_lat  = cyc - e.c;
    end
    if (acc) begin
      e.w = |req_we_i;
      e.d = e.w ? '0 : gold[req_addr_i];
      e.c = cyc;
      q.push_back(e);
      for (int l = 0; l < NWE; l++)
        if (req_we_i[l]) gold[req_addr_i][l*BW +: BW] = req_wdata_i[l*BW +: BW];
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic new_req();
    req_valid_i = 1'b1;
    req_addr_i  = AW'($urandom_range(DEPTH - 1, 16));
    req_we_i    = ($urandom % 2 == 0) ? '0 : NWE'($urandom);
    req_wdata_i = $urandom;
  endtask

  task automatic test_reset();
    req_valid_i = 1'b1;
    rsp_ready_i = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    total++;
    if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid_o); end
    total++;
    if (req_ready_o !== 1'b0) begin bad++; $display("FAIL reset_req_ready: got %b expected 0", req_ready_o); end
    total++;
    if (ram_en_o !== 1'b0) begin bad++; $display("FAIL reset_ram_en: got %b expected 0", ram_en_o); end
    repeat (2) @(negedge clk);
    req_valid_i = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle();
    total++;
    if (rdy_seen !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b expected 1", rdy_seen); end
    $display("test_reset: done");
  endtask

  task automatic test_back_to_back();
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      req_valid_i = (i < 16);
      req_we_i    = (i < 8) ? '1 : '0;
      req_addr_i  = AW'(i % 8);
      req_wdata_i = DW'(32'hA0 + (i % 8));
      cycle();
      if (i < 16) begin
        total++;
        if (rdy_seen !== 1'b1) begin bad++; $display("FAIL b2b_ready cyc %0d: got %b expected 1", i, rdy_seen); end
      end
      if (got) begin
        total++;
        if (!have_exp || obs_w !== exp_w || obs_d !== exp_d || exp_lat != 1) begin
          bad++;
          $display("FAIL b2b_rsp: got w=%0b d=%h lat=%0d expected w=%0b d=%h lat=1", obs_w, obs_d, exp_lat, exp_w, exp_d);
        end
        $display("b2b rsp: w=%0b d=%h", obs_w, obs_d);
      end
    end
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL b2b_outstanding: got %0d expected 0", q.size()); end
  endtask

  task automatic test_byte_write();
    logic [DW-1:0] wd [3];
    logic [NWE-1:0] wm [3];
    int nrd = 0;
    wd[0] = 32'h11223344; wm[0] = 4'hF;
    wd[1] = 32'hAABBCCDD; wm[1] = 4'b0010;
    wd[2] = 32'h0;        wm[2] = 4'h0;
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_valid_i = (i < 3);
      req_addr_i  = 8'd5;
      req_we_i    = (i < 3) ? wm[i] : '0;
      req_wdata_i = (i < 3) ? wd[i] : '0;
      cycle();
      if (got) begin
        total++;
        if (!have_exp || obs_w !== exp_w || obs_d !== exp_d) begin
          bad++;
          $display("FAIL byte_rsp: got w=%0b d=%h expected w=%0b d=%h", obs_w, obs_d, exp_w, exp_d);
        end
        if (!obs_w) begin
          nrd++;
          total++;
          if (obs_d !== 32'h1122CC44) begin bad++; $display("FAIL byte_merge: got %h expected 1122cc44", obs_d); end
        end
        $display("byte rsp: w=%0b d=%h", obs_w, obs_d);
      end
    end
    total++;
    if (nrd != 1) begin bad++; $display("FAIL byte_read_count: got %0d expected 1", nrd); end
  endtask

  task automatic test_backpressure();
    int n_acc = 0;
    int n_rsp = 0;
    int guard = 0;
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1;
    req_we_i    = '0;
    req_addr_i  = '0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (acc) begin n_acc++; req_addr_i = AW'(n_acc); end
    end
    total++;
    if (n_acc != RD) begin bad++; $display("FAIL bp_accepted: got %0d expected %0d", n_acc, RD); end
    total++;
    if (req_ready_o !== 1'b0) begin bad++; $display("FAIL bp_ready_low: got %b expected 0", req_ready_o); end
    rsp_ready_i = 1'b1;
    while ((n_rsp < 4 || q.size() != 0) && guard < 30) begin
      if (n_acc >= 4) req_valid_i = 1'b0;
      cycle();
      guard++;
      if (acc) begin n_acc++; req_addr_i = AW'(n_acc); end
      if (got) begin
        total++;
        if (!have_exp || obs_w !== 1'b0 || obs_d !== DW'(32'hA0 + n_rsp) || obs_d !== exp_d) begin
          bad++;
          $display("FAIL bp_rsp %0d: got w=%0b d=%h expected w=0 d=%h", n_rsp, obs_w, obs_d, 32'hA0 + n_rsp);
        end
        $display("bp rsp %0d: d=%h", n_rsp, obs_d);
        n_rsp++;
      end
    end
    req_valid_i = 1'b0;
    total++;
    if (n_rsp != 4 || n_acc != 4) begin bad++; $display("FAIL bp_counts: got acc=%0d rsp=%0d expected 4 and 4", n_acc, n_rsp); end
  endtask

  task automatic test_push_pop();
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1;
    req_we_i    = '0;
    req_addr_i  = 8'd3;
    cycle();
    for (int i = 0; i < 80; i++) begin
      if (acc || !req_valid_i) new_req();
      rsp_ready_i = ~rsp_ready_i;
      cycle();
      total++;
      if (q.size() > RD) begin bad++; $display("FAIL pp_outstanding: got %0d expected <= %0d", q.size(), RD); end
      if (got) begin
        total++;
        if (!have_exp || obs_w !== exp_w || obs_d !== exp_d) begin
          bad++;
          $display("FAIL pp_rsp: got w=%0b d=%h expected w=%0b d=%h", obs_w, obs_d, exp_w, exp_d);
        end
        $display("pp rsp: w=%0b d=%h", obs_w, obs_d);
      end
    end
    req_valid_i = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if (acc || !req_valid_i) begin
        if ($urandom % 4 != 0) new_req(); else req_valid_i = 1'b0;
      end
      rsp_ready_i = ($urandom % 10 < 7);
      cycle();
      total++;
      if (en_seen !== acc || we_seen !== (acc ? we_drv : '0)) begin
        bad++;
        $display("FAIL rnd_ram_strobe: got en=%b we=%h expected en=%b we=%h", en_seen, we_seen, acc, acc ? we_drv : '0);
      end
      if (got) begin
        total++;
        if (!have_exp || obs_w !== exp_w || obs_d !== exp_d) begin
          bad++;
          $display("FAIL rnd_rsp: got w=%0b d=%h expected w=%0b d=%h", obs_w, obs_d, exp_w, exp_d);
        end
        $display("rnd rsp: w=%0b d=%h", obs_w, obs_d);
      end
    end
    req_valid_i = 1'b0;
  endtask

  task automatic test_drain();
    int guard = 0;
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b0;
    while (q.size() != 0 && guard < 20) begin
      cycle();
      guard++;
      if (got) begin
        total++;
        if (!have_exp || obs_w !== exp_w || obs_d !== exp_d) begin
          bad++;
          $display("FAIL drain_rsp: got w=%0b d=%h expected w=%0b d=%h", obs_w, obs_d, exp_w, exp_d);
        end
        $display("drain rsp: w=%0b d=%h", obs_w, obs_d);
      end
    end
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL drain_timeout: got %0d outstanding expected 0", q.size()); end
    cycle();
    total++;
    if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL drain_idle_valid: got %b expected 0", rsp_valid_o); end
  endtask

  task automatic test_mid_reset();
    int nrd = 0;
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1;
    req_we_i    = '0;
    req_addr_i  = 8'd5;
    repeat (4) cycle();
    total++;
    if (q.size() != RD) begin bad++; $display("FAIL mr_fill: got %0d outstanding expected %0d", q.size(), RD); end
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    total++;
    if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL mr_rsp_valid: got %b expected 0", rsp_valid_o); end
    total++;
    if (req_ready_o !== 1'b0) begin bad++; $display("FAIL mr_req_ready: got %b expected 0", req_ready_o); end
    total++;
    if (ram_en_o !== 1'b0) begin bad++; $display("FAIL mr_ram_en: got %b expected 0", ram_en_o); end
    repeat (2) @(negedge clk);
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle();
    total++;
    if (rdy_seen !== 1'b1 || got) begin bad++; $display("FAIL mr_release: got ready=%b rsp=%b expected ready=1 rsp=0", rdy_seen, got); end
    for (int i = 0; i < 3; i++) begin
      req_valid_i = (i == 0);
      cycle();
      if (got) begin
        nrd++;
        total++;
        if (obs_w !== 1'b0 || obs_d !== 32'h1122CC44 || !have_exp || obs_d !== exp_d) begin
          bad++;
          $display("FAIL mr_read5: got w=%0b d=%h expected w=0 d=1122cc44", obs_w, obs_d);
        end
        $display("mr rsp: d=%h", obs_d);
      end
    end
    total++;
    if (nrd != 1) begin bad++; $display("FAIL mr_read_count: got %0d expected 1", nrd); end
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) begin
      ram[a]  = '0;
      gold[a] = '0;
    end
    acc = 1'b0;
    test_reset();
    test_back_to_back();
    test_byte_write();
    test_backpressure();
    test_push_pop();
    test_drain();
    test_mid_reset();
    test_random();
    test_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
